// File: rtl/m3_ramp_sequencer_pkg.sv
// Shared types, default timing constants and the length clamp helper for the
// 3-phase motor ramp sequencer.
package m3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCEL = 3'd1,
        ST_RUN   = 3'd2,
        ST_SLOW  = 3'd3,
        ST_DECEL = 3'd4,
        ST_DWELL = 3'd5
    } state_t;

    // Silicon defaults; simulation builds override with 300 / 40 / 16.
    localparam int unsigned PERIOD_MAX_DEF = 4000000;
    localparam int unsigned PERIOD_MIN_DEF = 40;
    localparam int unsigned DWELL_CYC_DEF  = 1000;

    // Clamp a round length into [lo, hi].
    function automatic logic [31:0] clamp_len(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [31:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/m3_ramp_sequencer_if.sv
// Control/status bundle between the motor host logic and the ramp sequencer.
interface m3_ramp_sequencer_if;

    logic        startI;
    logic        stopI;
    logic        forceStopI;
    logic        invRotateReqI;
    logic [31:0] targetLenI;
    logic [31:0] dstRoundLenI;
    logic        workingO;
    logic        speedIncO;
    logic        speedDecO;
    logic        nextRound_1O;
    logic        invRotateO;
    logic        atSpeedO;
    logic [2:0]  stateO;

    modport slave (
        input  startI, stopI, forceStopI, invRotateReqI, targetLenI, dstRoundLenI,
        output workingO, speedIncO, speedDecO, nextRound_1O, invRotateO, atSpeedO, stateO
    );

    modport master (
        output startI, stopI, forceStopI, invRotateReqI, targetLenI, dstRoundLenI,
        input  workingO, speedIncO, speedDecO, nextRound_1O, invRotateO, atSpeedO, stateO
    );

endinterface

// File: rtl/m3_ramp_sequencer_round_timer.sv
// Round timer: counts clocks while enabled and emits a one-cycle registered
// strobe when the count reaches len-1, then restarts at zero.
module m3_round_timer (
    input  logic        clkI,
    input  logic        rstI,
    input  logic        enI,
    input  logic [31:0] lenI,
    output logic        strobeO
);

    logic [31:0] cnt_q, cnt_d;
    logic        strobe_q, strobe_d;
    logic        round_end;

    // A length shrinking below the current count ends the round on the next clock.
    assign round_end = (lenI == 32'd0) || (cnt_q >= (lenI - 32'd1));

    // Next count and strobe.
    always_comb begin
        cnt_d    = cnt_q + 32'd1;
        strobe_d = 1'b0;
        if (!enI) begin
            cnt_d = 32'd0;
        end else if (round_end) begin
            cnt_d    = 32'd0;
            strobe_d = 1'b1;
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            cnt_q    <= 32'd0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobeO = strobe_q;

endmodule

// File: rtl/m3_ramp_sequencer.sv
// Start/stop/reverse sequencer for the 3-phase motor speed path.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | motor off; direction may be flipped directly
// ACCEL    | requesting shorter rounds until at or below target
// RUN      | holding at target length
// SLOW     | requesting longer rounds until at or above target
// DECEL    | controlled stop, lengthening rounds up to PERIOD_MAX
// DWELL    | speed calc disabled for DWELL_CYC clocks before reversing
module m3_ramp_sequencer
    import m3_pkg::*;
#(
    parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF,
    parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF,
    parameter int unsigned DWELL_CYC  = DWELL_CYC_DEF
) (
    input  logic               clkI,
    input  logic               rstI,
    m3_ramp_sequencer_if.slave bus
);

    localparam logic [31:0] P_MAX    = 32'(PERIOD_MAX);
    localparam logic [31:0] P_MIN    = 32'(PERIOD_MIN);
    localparam logic [31:0] DWELL_LD = 32'(DWELL_CYC - 1);

    state_t      state_q, state_d;
    logic        rev_pend_q, rev_pend_d;
    logic        inv_rotate_q, inv_rotate_d;
    logic [31:0] dwell_cnt_q, dwell_cnt_d;
    logic        working_q, working_d;
    logic        speed_inc_q, speed_inc_d;
    logic        speed_dec_q, speed_dec_d;
    logic        at_speed_q, at_speed_d;

    logic [31:0] tgt;
    logic [31:0] dst;
    logic [31:0] round_len;
    logic [32:0] slow_thresh;
    logic        slow_req;
    logic        timer_en;
    logic        next_round;

    assign dst       = bus.dstRoundLenI;
    assign tgt       = clamp_len(bus.targetLenI, P_MIN, P_MAX);
    assign round_len = clamp_len(dst, P_MIN, 32'hFFFF_FFFF);

    // Hysteresis band of 1/16 above the current length; kept 33-bit so a
    // large length cannot wrap into a false SLOW request.
    assign slow_thresh = {1'b0, dst} + {5'b0_0000, dst[31:4]};
    assign slow_req    = ({1'b0, tgt} >= slow_thresh);

    // Next state, direction, pending-reverse flag and dwell counter.
    always_comb begin
        state_d      = state_q;
        rev_pend_d   = rev_pend_q;
        inv_rotate_d = inv_rotate_q;
        dwell_cnt_d  = dwell_cnt_q;
        if (bus.forceStopI) begin
            state_d    = ST_IDLE;
            rev_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.stopI) begin
                        if (bus.invRotateReqI) begin
                            inv_rotate_d = ~inv_rotate_q;
                        end else if (bus.startI) begin
                            state_d = ST_ACCEL;
                        end
                    end
                end
                ST_ACCEL, ST_RUN, ST_SLOW: begin
                    if (bus.stopI) begin
                        state_d    = ST_DECEL;
                        rev_pend_d = 1'b0;
                    end else if (bus.invRotateReqI) begin
                        state_d    = ST_DECEL;
                        rev_pend_d = 1'b1;
                    end else begin
                        case (state_q)
                            ST_ACCEL: if (dst <= tgt) state_d = ST_RUN;
                            ST_RUN: begin
                                if (dst > tgt) begin
                                    state_d = ST_ACCEL;
                                end else if (slow_req) begin
                                    state_d = ST_SLOW;
                                end
                            end
                            default: if (dst >= tgt) state_d = ST_RUN;
                        endcase
                    end
                end
                ST_DECEL: begin
                    // A plain stop arriving mid-decel cancels a pending reverse.
                    if (bus.stopI) begin
                        rev_pend_d = 1'b0;
                    end
                    if (dst >= P_MAX) begin
                        if (rev_pend_d) begin
                            state_d      = ST_DWELL;
                            inv_rotate_d = ~inv_rotate_q;
                            rev_pend_d   = 1'b0;
                            dwell_cnt_d  = DWELL_LD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DWELL: begin
                    if (bus.stopI) begin
                        state_d = ST_IDLE;
                    end else if (dwell_cnt_q == 32'd0) begin
                        state_d = ST_ACCEL;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    rev_pend_d = 1'b0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        working_d   = 1'b0;
        speed_inc_d = 1'b0;
        speed_dec_d = 1'b0;
        at_speed_d  = 1'b0;
        case (state_d)
            ST_ACCEL: begin
                working_d   = 1'b1;
                speed_inc_d = 1'b1;
            end
            ST_RUN: begin
                working_d  = 1'b1;
                at_speed_d = 1'b1;
            end
            ST_SLOW, ST_DECEL: begin
                working_d   = 1'b1;
                speed_dec_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, flags and output registers.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state_q      <= ST_IDLE;
            rev_pend_q   <= 1'b0;
            inv_rotate_q <= 1'b0;
            dwell_cnt_q  <= 32'd0;
            working_q    <= 1'b0;
            speed_inc_q  <= 1'b0;
            speed_dec_q  <= 1'b0;
            at_speed_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rev_pend_q   <= rev_pend_d;
            inv_rotate_q <= inv_rotate_d;
            dwell_cnt_q  <= dwell_cnt_d;
            working_q    <= working_d;
            speed_inc_q  <= speed_inc_d;
            speed_dec_q  <= speed_dec_d;
            at_speed_q   <= at_speed_d;
        end
    end

    // Force stop clears the round timer on the same edge it leaves the state.
    assign timer_en = working_q & ~bus.forceStopI;

    m3_round_timer u_round_timer (
        .clkI    (clkI),
        .rstI    (rstI),
        .enI     (timer_en),
        .lenI    (round_len),
        .strobeO (next_round)
    );

    assign bus.workingO     = working_q;
    assign bus.speedIncO    = speed_inc_q;
    assign bus.speedDecO    = speed_dec_q;
    assign bus.atSpeedO     = at_speed_q;
    assign bus.invRotateO   = inv_rotate_q;
    assign bus.nextRound_1O = next_round;
    assign bus.stateO       = state_q;

endmodule

// File: doc/m3_ramp_sequencer.md
# m3_ramp_sequencer

Start/stop/reverse sequencer for the 3‑phase motor speed path. It drives the speed‑calc block's `working`, `INC`/`DEC` and next‑round controls, and consumes its round length `dstRoundLen`. It ramps the motor to a target round length, holds it there, and performs controlled stops and direction reversals with a dead dwell between them. It owns the round timer that generates the one‑cycle next‑round strobe.

## Interface
Parameters:
- `PERIOD_MAX`, 4000000: slowest round length in clocks; stop threshold (300 in simulation builds).
- `PERIOD_MIN`, 40: fastest allowed round length in clocks.
- `DWELL_CYC`, 1000: clocks with `workingO`=0 between stopping and restarting on reverse (16 in simulation).

Ports:
- `clkI` in 1: system clock.
- `rstI` in 1: reset. Asynchronous, active‑high; one clock domain.
- `startI` in 1: start request, pulse or level.
- `stopI` in 1: controlled stop request.
- `forceStopI` in 1: immediate stop.
- `invRotateReqI` in 1: direction reversal request.
- `targetLenI` in 32: desired round length.
- `dstRoundLenI` in 32: current round length from the speed calc.
- `workingO` out 1: enables the speed calc.
- `speedIncO` out 1: request a shorter period.
- `speedDecO` out 1: request a longer period.
- `nextRound_1O` out 1: one‑cycle strobe at the end of each round.
- `invRotateO` out 1: current direction.
- `atSpeedO` out 1: high in RUN.
- `stateO` out 3: state encoding, for debug.

## Operation
- **Target clamp:** `tgt` = `targetLenI` clamped to [`PERIOD_MIN`, `PERIOD_MAX`].
- **Registered request flag:** `revPend`.
- **States:** IDLE=0, ACCEL=1, RUN=2, SLOW=3, DECEL=4, DWELL=5.
- **IDLE**
  - All outputs 0 except `invRotateO`.
  - `startI` → ACCEL.
  - `invRotateReqI` toggles `invRotateO` directly, with no dwell.
- **ACCEL**
  - `speedIncO`=1.
  - `dstRoundLenI` ≤ `tgt` → RUN.
- **RUN**
  - `atSpeedO`=1.
  - `dstRoundLenI` > `tgt` → ACCEL.
  - `tgt` ≥ `dstRoundLenI` + `dstRoundLenI[31:4]` → SLOW. The sum is computed 33‑bit; no wrap.
- **SLOW**
  - `speedDecO`=1.
  - `dstRoundLenI` ≥ `tgt` → RUN.
- **Stop/reverse from ACCEL, RUN or SLOW**
  - `stopI` → DECEL with `revPend`=0.
  - `invRotateReqI` → DECEL with `revPend`=1.
- **DECEL**
  - `speedDecO`=1.
  - `dstRoundLenI` ≥ `PERIOD_MAX`: if `revPend`=1 → DWELL; otherwise → IDLE.
  - `startI` and further reverse requests are ignored.
- **DWELL**
  - `workingO`=0.
  - On entry: toggle `invRotateO`, clear `revPend`, load the dwell counter with `DWELL_CYC`‑1.
  - At count 0 → ACCEL.
  - `stopI` during DWELL → IDLE.
- **`workingO`** = 1 in ACCEL, RUN, SLOW and DECEL.
- **`forceStopI`** → IDLE from any state on the next clock. It also clears `revPend` and the round timer. Direction is unchanged.
- **Priority, highest first:** `forceStopI`, `stopI`, `invRotateReqI`, `startI`, speed comparisons.
- **Round timer**
  - 32‑bit counter, cleared while `workingO`=0.
  - `len` = `dstRoundLenI` clamped to ≥ `PERIOD_MIN`, sampled each cycle.
  - When counter ≥ `len`‑1: `nextRound_1O`=1 for one cycle and the counter restarts at 0.
  - A mid‑round decrease of `len` below the count fires on the next cycle.

## Timing
- All outputs are registered Moore outputs.
- Every output is 0 during and after reset, including `invRotateO`; `stateO` = IDLE.
- Input to state/output latency is 1 clock.
- `INC`/`DEC` are never high together.
- The first `nextRound_1O` comes `len` clocks after `workingO` rises; strobes then repeat every `len` clocks.
- Reset asserted mid‑operation returns everything to reset values asynchronously.
- DWELL lasts exactly `DWELL_CYC` clocks with `workingO`=0.

## Structure
- **Package `m3_pkg`:**
  - state enum (3‑bit);
  - default values for `PERIOD_MAX`, `PERIOD_MIN` and `DWELL_CYC`;
  - a `clamp_len` function.
- **Sub‑module `m3_round_timer`:** counter plus strobe. Inputs: `clkI`, `rstI`, `enI`, `lenI`. Output: `strobeO`.
- **Top level:** FSM, `revPend`, dwell counter and target comparators.

## Test plan
All scenarios use `PERIOD_MAX`=300, `PERIOD_MIN`=40, `DWELL_CYC`=16. The bench pairs this block with the speed‑calc model and checks, every clock, that INC and DEC are never both high.

1. **Reset:** `rstI` pulse mid‑RUN → all outputs 0 and `stateO`=0 immediately, asynchronously.
2. **Start to target:** `startI`, `targetLenI`=100 → ACCEL with `speedIncO`=1; `nextRound_1O` every 300 clocks initially. `dstRoundLenI` ≤ 100 → RUN and `atSpeedO`=1; strobe period equals `dstRoundLenI`.
3. **Retarget slower:** in RUN at 90, `targetLenI`=200 → SLOW with `speedDecO`=1 until `dstRoundLenI` ≥ 200, then RUN.
4. **Reverse:** in RUN, `invRotateReqI` → DECEL until `dstRoundLenI`=300. Then DWELL: `workingO`=0 for 16 clocks, `invRotateO` toggles 0→1. Then ACCEL.
5. **Force stop:** `forceStopI` together with `startI` in DECEL with `revPend`=1 → IDLE next clock, no direction toggle, no strobes.
6. **Target clamp:** `targetLenI`=0 → ramp settles at 40 (`PERIOD_MIN`). `targetLenI`=0xFFFFFFFF while in RUN → SLOW until 300; no arithmetic wrap.
